// File: rtl/alu_src_b_stage.sv
// ALU source-B operand select stage with a 2-entry skid buffer and sticky select-error tracking.
// Optional macro ALU_SRC_B_SHIFT2_EN: sel code N_SRC+1 yields slot N_SRC-1 shifted left by 2.
module alu_src_b_stage #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      N_SRC     = 3,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(4)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             sel,
    input  logic [N_SRC*WIDTH-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   sel_err,
    output logic [7:0]             err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  main_data_p1;
    logic [WIDTH-1:0]  skid_data_p1;
    logic [WIDTH-1:0]  sel_word;
    logic              sel_oor;
    logic              vld_p1;
    logic              in_xfer, out_xfer;
    logic              main_load, main_from_skid, skid_load;

    // Returns {out_of_range, operand}; an out-of-range code yields a zero operand.
    function automatic logic [WIDTH:0] select_operand(input logic [2:0] s,
                                                      input logic [N_SRC*WIDTH-1:0] d);
        logic [WIDTH:0] r;
        r = {1'b1, {WIDTH{1'b0}}};
        if (s == 3'd0)
            r = {1'b0, d[WIDTH-1:0]};
        else if (s == 3'd1)
            r = {1'b0, CONST_VAL};
        for (int k = 1; k < int'(N_SRC); k++) begin
            if (int'(s) == k + 1)
                r = {1'b0, d[k*WIDTH +: WIDTH]};
        end
`ifdef ALU_SRC_B_SHIFT2_EN
        if (int'(s) == int'(N_SRC) + 1)
            r = {1'b0, d[(N_SRC-1)*WIDTH +: WIDTH] << 2};
`endif
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign {sel_oor, sel_word} = select_operand(sel, data_in);

    assign vld_p1    = (state != EMPTY);
    assign out_valid = vld_p1;
    assign out_data  = main_data_p1;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = vld_p1 && out_ready;

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_nxt      = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Stage p1: operand registers; in_ready is precomputed from the next state so it stays a flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= EMPTY;
            in_ready     <= 1'b1;
            main_data_p1 <= '0;
            sel_err      <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
            if (main_load)
                main_data_p1 <= sel_word;
            else if (main_from_skid)
                main_data_p1 <= skid_data_p1;
            if (in_xfer && sel_oor) begin
                sel_err   <= 1'b1;
                err_count <= sat_inc8(err_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (skid_load)
            skid_data_p1 <= sel_word;
    end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Self-checking bench for alu_src_b_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_src_b_stage;

    localparam int W = 32;
    localparam int N = 3;
    localparam logic [W-1:0] CV = 32'd4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     sel;
    logic [N*W-1:0] data_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           sel_err;
    logic [7:0]     err_count;

    logic [W-1:0]   slot [N];

    logic [W-1:0]   q[$];
    logic [W-1:0]   shown;
    logic           m_err;
    int             m_cnt;
    int             checks = 0;
    int             errors = 0;

    alu_src_b_stage #(.WIDTH(W), .N_SRC(N), .CONST_VAL(CV)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference select rule written directly from the operand map.
    task automatic ref_op(input int s, output logic [W-1:0] v, output logic oor);
        oor = 1'b0;
        v   = '0;
        if (s == 0)
            v = slot[0];
        else if (s == 1)
            v = CV;
        else if (s >= 2 && s <= N)
            v = slot[s-1];
`ifdef ALU_SRC_B_SHIFT2_EN
        else if (s == N + 1)
            v = {slot[N-1][W-3:0], 2'b00};
`endif
        else
            oor = 1'b1;
    endtask

    // One clock: predict transfers from the current inputs, advance the model, then compare.
    task automatic step();
        logic         inx, outx, oor;
        logic [W-1:0] v;
        data_in = {slot[2], slot[1], slot[0]};
        inx  = in_valid && (q.size() < 2);
        outx = out_ready && (q.size() > 0);
        ref_op(int'(sel), v, oor);
        @(posedge clk);
        if (!reset) begin
            q.delete();
            shown = '0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (outx)
                void'(q.pop_front());
            if (inx) begin
                q.push_back(v);
                if (oor) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            if (q.size() > 0) shown = q[0];
        end
        #1;
        chk("out_valid", W'(out_valid), W'(q.size() > 0));
        chk("in_ready",  W'(in_ready),  W'(q.size() < 2));
        chk("out_data",  out_data, shown);
        chk("sel_err",   W'(sel_err), W'(m_err));
        chk("err_count", W'(err_count), W'(m_cnt));
    endtask

    initial begin
        shown = '0; m_err = 1'b0; m_cnt = 0;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 3'd0;
        slot[0] = 32'h0000_0011; slot[1] = 32'h0000_0022; slot[2] = 32'h0000_0033;
        data_in = '0;

        // reset state
        step(); step();
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_in_ready",  W'(in_ready), 1);
        chk("rst_out_data",  out_data, 0);

        // back-to-back selects 0/1/2
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        sel = 3'd0; step(); chk("seq_0x11", out_data, 32'h11);
        sel = 3'd1; step(); chk("seq_const", out_data, 32'h4);
        sel = 3'd2; step(); chk("seq_0x22", out_data, 32'h22);
        chk("seq_valid", W'(out_valid), 1);
        in_valid = 1'b0; step();

        // backpressure fills both entries, then drains in order
        out_ready = 1'b0; in_valid = 1'b1;
        sel = 3'd0; step();
        sel = 3'd1; step(); chk("bp_full_ready", W'(in_ready), 0);
        sel = 3'd2; step(); chk("bp_hold_data", out_data, 32'h11);
        out_ready = 1'b1; step(); chk("bp_drain_2nd", out_data, 32'h4);
        step(); chk("bp_third", out_data, 32'h22);
        in_valid = 1'b0; step();

        // out-of-range selects and counter saturation
        reset = 1'b0; step(); reset = 1'b1;
        in_valid = 1'b1; sel = 3'd7;
        step();
        chk("oor_data", out_data, 0);
        chk("oor_err", W'(sel_err), 1);
        chk("oor_cnt1", W'(err_count), 1);
        for (int i = 1; i < 300; i++) step();
        chk("oor_sat", W'(err_count), 255);

        // code N_SRC+1: shifted branch offset or out of range depending on build
        slot[2] = 32'h4000_0003; sel = 3'd4; step();
`ifdef ALU_SRC_B_SHIFT2_EN
        chk("shift2", out_data, 32'h0000_000C);
`else
        chk("code4_oor", out_data, 0);
`endif
        in_valid = 1'b0; step();

        // reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0;
        step(); step();
        chk("full_before_rst", W'(in_ready), 0);
        reset = 1'b0; step(); reset = 1'b1; in_valid = 1'b0;
        chk("rstf_valid", W'(out_valid), 0);
        chk("rstf_data", out_data, 0);
        chk("rstf_ready", W'(in_ready), 1);
        chk("rstf_cnt", W'(err_count), 0);

        // steady streaming through ONE
        out_ready = 1'b1; in_valid = 1'b1; sel = 3'd2;
        step();
        for (int i = 0; i < 10; i++) begin
            slot[1] = $urandom; sel = 3'($urandom_range(0, 3));
            step();
            chk("stream_valid", W'(out_valid), 1);
            chk("stream_ready", W'(in_ready), 1);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < N; k++) slot[k] = $urandom;
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            reset     = ($urandom_range(0, 60) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_src_b_stage.md
ALU_SRC_B_STAGE -- requirements
Module: alu_src_b_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand data width in bits.
REQ-002 Parameter N_SRC, default 3, number of data sources (legal 2..6).
REQ-003 Parameter CONST_VAL, default 4, WIDTH-bit constant source (PC increment).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  request carries a valid sel/data set.
REQ-007 in_ready  output  1  stage can accept a request this cycle.
REQ-008 sel  input  3  source select code.
REQ-009 data_in  input  N_SRC*WIDTH  packed sources; slot k at bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  out_data holds a selected operand.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 out_data  output  WIDTH  selected operand.
REQ-013 sel_err  output  1  sticky flag, an out-of-range sel was accepted.
REQ-014 err_count  output  8  saturating count of accepted out-of-range sels.

Function
REQ-015 Select map: sel 0 -> slot 0; sel 1 -> CONST_VAL; sel 2..N_SRC -> slot sel-1; any other code is out of range.
REQ-016 Out-of-range select produces operand 0 and sets sel_err and increments err_count (saturates at 255, no wrap).
REQ-017 Request transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Selection is evaluated on the transfer cycle; operand is registered; first out_valid one cycle after transfer (latency 1).
REQ-019 Storage is a 2-entry skid buffer (main + skid register), FIFO order preserved.
REQ-020 States: EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
REQ-021 EMPTY: in_ready=1; transfer -> ONE.
REQ-022 ONE: in_ready=1; transfer only -> FULL; output only -> EMPTY; both -> ONE with main replaced by new operand.
REQ-023 FULL: in_ready=0; output transfer -> ONE with skid moved to main; input ignored.
REQ-024 in_ready is a registered signal (depends only on state, no combinational path from out_ready).
REQ-025 out_data and out_valid are driven from the main register only; out_data holds stable while out_valid && !out_ready.
REQ-026 Requests with in_valid=1 while in_ready=0 are not consumed and do not affect sel_err/err_count.
REQ-027 Sustained throughput 1 operand/cycle when out_ready is held high.

Reset
REQ-028 While reset=0 at a rising edge: state EMPTY, out_valid=0, out_data=0, sel_err=0, err_count=0, in_ready=1 after that edge.
REQ-029 Reset mid-operation discards all buffered operands; no output transfer occurs on the reset edge.

Configuration
REQ-030 Macro ALU_SRC_B_SHIFT2_EN defined: sel code N_SRC+1 selects slot N_SRC-1 shifted left 2 (low bits zero, upper 2 bits dropped), used for branch offsets.
REQ-031 Macro ALU_SRC_B_SHIFT2_EN undefined: code N_SRC+1 is out of range per REQ-016.

Verification
REQ-032 Defaults, out_ready=1, sel=0/1/2 with slot0=0x0000_0011, slot1=0x0000_0022 -> out_data 0x11, 0x4, 0x22 on consecutive cycles, out_valid continuous.
REQ-033 out_ready=0, three requests offered -> first two accepted, in_ready=0 from third cycle; release out_ready -> 0x11 then 0x4 in order, third accepted after drain.
REQ-034 sel=7 accepted (macro off) -> out_data=0, sel_err=1, err_count=1; 300 such requests -> err_count=255.
REQ-035 Macro on, sel=4, slot2=0x4000_0003 -> out_data 0x0000_000C.
REQ-036 State FULL, reset=0 one cycle -> out_valid=0, out_data=0, in_ready=1, err_count=0 next cycle.
REQ-037 In ONE with in_valid=1, out_ready=1 every cycle for 10 cycles -> state stays ONE, 10 operands delivered in order.
